// File: rtl/d_flipflop_b.sv
// -----------------------------------------------------------------------------
// d_flipflop_b
//
// Parameterised D-type register pipeline with a synchronous, active-high reset.
// With the default parameters (WIDTH=1, DEPTH=1) it is a plain 1-bit D
// flip-flop. For larger DEPTH it acts as a DEPTH-cycle registered delay line.
//
// Parameters:
//   WIDTH        data width in bits (>= 1)
//   DEPTH        number of register stages, equal to clk-to-q latency (>= 1)
//   RESET_VALUE  value loaded into every stage on a reset edge
//
// Ports:
//   clk      in   1      clock, rising edge only
//   rst_n    in   1      synchronous reset, ACTIVE-HIGH despite the name
//                        (rst_n=1 resets); it only acts at a rising edge
//   d        in   WIDTH  data input, sampled at the rising edge
//   q        out  WIDTH  last pipeline stage
//   changed  out  1      only when D_FLIPFLOP_B_CHANGE_FLAG_EN is defined:
//                        high for the cycle after an edge that changed q
//
// Build option:
//   D_FLIPFLOP_B_CHANGE_FLAG_EN  adds the registered "changed" output.
//                                Behaviour on q is identical either way.
// -----------------------------------------------------------------------------
module d_flipflop_b #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
    ,
    output logic             changed
`endif
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift path: stage 0 takes d, each later stage takes its predecessor.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers: reset flushes every stage, otherwise shift each edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
    // armed_q is low on the reset edge and on the first edge after release,
    // so the RESET_VALUE -> first-data transition never raises changed.
    logic armed_q;
    logic armed_d;
    logic changed_q;
    logic changed_d;

    // Next-state for the change detector, comparing incoming and current q.
    always_comb begin
        armed_d   = 1'b1;
        changed_d = 1'b0;
        if (armed_q) begin
            changed_d = (stage_d[DEPTH-1] != stage_q[DEPTH-1]);
        end else begin
            changed_d = 1'b0;
        end
    end

    // Change-detector registers, cleared on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            armed_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;
`endif

endmodule

// File: tb/tb_d_flipflop_b.sv
// -----------------------------------------------------------------------------
// tb_d_flipflop_b
//
// Directed bench for d_flipflop_b. Two instances share one clock:
//   u_a : defaults (WIDTH=1, DEPTH=1, RESET_VALUE=0)
//   u_b : WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5
// Clock period 10, rising edges at t=5, 15, 25, ... Inputs change away from
// rising edges; outputs are sampled 2 time units after an edge or mid-cycle.
// -----------------------------------------------------------------------------
module tb_d_flipflop_b;

    logic       clk;
    logic       rst_a;
    logic [0:0] d_a;
    logic [0:0] q_a;
    logic       rst_b;
    logic [7:0] d_b;
    logic [7:0] q_b;
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
    logic       chg_a;
    logic       chg_b;
`endif

    int checks;
    int failures;

    d_flipflop_b u_a (
        .clk     (clk),
        .rst_n   (rst_a),
        .d       (d_a),
        .q       (q_a)
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        ,
        .changed (chg_a)
`endif
    );

    d_flipflop_b #(
        .WIDTH       (8),
        .DEPTH       (3),
        .RESET_VALUE (8'hA5)
    ) u_b (
        .clk     (clk),
        .rst_n   (rst_b),
        .d       (d_b),
        .q       (q_b)
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        ,
        .changed (chg_b)
`endif
    );

    // Free-running clock, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed sequence; comments give absolute time after each delay.
    initial begin
        checks   = 0;
        failures = 0;
        rst_a = 1'b1; d_a = 1'b0;
        rst_b = 1'b1; d_b = 8'h00;

        #7;  // t=7, after reset edge at 5
        check("a_reset", {7'd0, q_a}, 8'h00);
        check("b_reset", q_b, 8'hA5);
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        check("a_chg_reset_edge", {7'd0, chg_a}, 8'h00);
        check("b_chg_reset_edge", {7'd0, chg_b}, 8'h00);
`endif
        #1 d_a = 1'b1;           // t=8  glitch on d between edges
        #1 d_a = 1'b0;           // t=9
        #1 begin rst_a = 1'b0; d_a = 1'b1; end  // t=10 release, d=1
        #4;                      // t=14
        check("a_no_capture_between_edges", {7'd0, q_a}, 8'h00);
        #3;                      // t=17
        check("a_capture_1", {7'd0, q_a}, 8'h01);
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        check("a_chg_first_after_release", {7'd0, chg_a}, 8'h00);
`endif
        #3 d_a = 1'b0;           // t=20
        #7;                      // t=27
        check("a_capture_0", {7'd0, q_a}, 8'h00);
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        check("a_chg_1to0", {7'd0, chg_a}, 8'h01);
`endif
        #1 d_a = 1'b1;           // t=28 glitch
        #1 d_a = 1'b0;           // t=29
        #1 d_a = 1'b1;           // t=30
        #2;                      // t=32
        check("a_no_async_d", {7'd0, q_a}, 8'h00);
        #5;                      // t=37
        check("a_capture_1b", {7'd0, q_a}, 8'h01);
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        check("a_chg_0to1", {7'd0, chg_a}, 8'h01);
`endif
        #3 rst_a = 1'b1;         // t=40, d stays 1
        #2;                      // t=42
        check("a_rst_waits_for_edge", {7'd0, q_a}, 8'h01);
        #5;                      // t=47
        check("a_mid_reset", {7'd0, q_a}, 8'h00);
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        check("a_chg_mid_reset_edge", {7'd0, chg_a}, 8'h00);
`endif
        #3 rst_a = 1'b0;         // t=50
        #7;                      // t=57
        check("a_after_release", {7'd0, q_a}, 8'h01);
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        check("a_chg_release_edge", {7'd0, chg_a}, 8'h00);
`endif
        #1 rst_a = 1'b1;         // t=58 2-unit reset pulse between edges
        #2 rst_a = 1'b0;         // t=60
        #2;                      // t=62
        check("a_rst_pulse_no_async", {7'd0, q_a}, 8'h01);
        #5;                      // t=67
        check("a_rst_pulse_ignored", {7'd0, q_a}, 8'h01);
`ifdef D_FLIPFLOP_B_CHANGE_FLAG_EN
        check("a_chg_steady", {7'd0, chg_a}, 8'h00);
`endif

        // Pipeline instance: release at t=70, capture edges 75, 85, 95, ...
        #3 begin rst_b = 1'b0; d_b = 8'h01; end  // t=70
        #7;                      // t=77, 1st edge
        check("b_flushed_edge1", q_b, 8'hA5);
        #3 d_b = 8'h02;          // t=80
        #7;                      // t=87, 2nd edge
        check("b_flushed_edge2", q_b, 8'hA5);
        #3 d_b = 8'h03;          // t=90
        #7;                      // t=97, 3rd edge
        check("b_pipe_01", q_b, 8'h01);
        #3 d_b = 8'h04;          // t=100
        #7;                      // t=107, 4th edge
        check("b_pipe_02", q_b, 8'h02);
        #3 d_b = 8'h05;          // t=110
        #7;                      // t=117, 5th edge
        check("b_pipe_03", q_b, 8'h03);
        #3 begin rst_b = 1'b1; d_b = 8'h06; end  // t=120 reset mid-flight
        #7;                      // t=127
        check("b_mid_reset", q_b, 8'hA5);
        #3 rst_b = 1'b0;         // t=130, d=06 captured at 135
        #7;                      // t=137
        check("b_discard_1", q_b, 8'hA5);
        #3 d_b = 8'h07;          // t=140
        #7;                      // t=147
        check("b_discard_2", q_b, 8'hA5);
        #10;                     // t=157
        check("b_pipe_06", q_b, 8'h06);
        #10;                     // t=167
        check("b_pipe_07", q_b, 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
